// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and its neighbours.
// Holds the NOP encoding, default reset PC and IF/ID bundle layout.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          IF_ID_INSTR_W = 32;
    localparam int          IF_ID_PC_W    = 32;

    typedef struct packed {
        logic [IF_ID_INSTR_W-1:0] instr;
        logic [IF_ID_PC_W-1:0]    pc4;
        logic                     valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{
        instr: NOP_INSTR,
        pc4:   '0,
        valid: 1'b0
    };

    // Fetch addresses are always word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating event counter: counts enabled cycles, sticks at all-ones.
// Ports: clk, reset (sync, high), en (count this edge), count (value).
module fetch_stage_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = W'(1);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (en && (count != '1))
            count <= count + ONE;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Ports: clk/reset, stall, redirect_valid/target in; imem_addr out,
// imem_data in; pc, if_id_{instr,pc4,valid}, fetch/flush counts out.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          IMEM_AW  = 10,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_data,
    output logic [31:0]        pc,
    output logic [31:0]        if_id_instr,
    output logic [31:0]        if_id_pc4,
    output logic               if_id_valid,
    output logic [CNT_W-1:0]   fetch_count,
    output logic [CNT_W-1:0]   flush_count
);

    if_id_t      if_id_q;
    logic [31:0] pc_plus4;
    logic        fetch_en;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc[IMEM_AW+1:2];

    // Redirect beats stall so a wrong-path word never survives in ID.
    assign fetch_en = ~redirect_valid & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            if_id_q <= IF_ID_BUBBLE;
        end else if (redirect_valid) begin
            pc      <= align_word(redirect_target);
            if_id_q <= IF_ID_BUBBLE;
        end else if (!stall) begin
            pc            <= pc_plus4;
            if_id_q.instr <= imem_data;
            if_id_q.pc4   <= pc_plus4;
            if_id_q.valid <= 1'b1;
        end
    end

    assign if_id_instr = if_id_q.instr;
    assign if_id_pc4   = if_id_q.pc4;
    assign if_id_valid = if_id_q.valid;

    fetch_stage_sat_counter #(.W(CNT_W)) u_fetch_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (fetch_en),
        .count (fetch_count)
    );

    fetch_stage_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (redirect_valid),
        .count (flush_count)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: reference model plus directed scenarios.
// A second instance with 2-bit counters exercises saturation.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;

    logic [9:0]  imem_addr,  imem_addr2;
    logic [31:0] imem_data,  imem_data2;
    logic [31:0] pc,         pc2;
    logic [31:0] instr,      instr2;
    logic [31:0] pc4,        pc4b;
    logic        valid,      valid2;
    logic [15:0] fc,         flc;
    logic [1:0]  fc2,        flc2;

    logic [31:0] mem [0:1023];

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    // Model state
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_fc, m_flc, m_fc2, m_flc2;

    assign imem_data  = mem[imem_addr];
    assign imem_data2 = mem[imem_addr2];

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .pc              (pc),
        .if_id_instr     (instr),
        .if_id_pc4       (pc4),
        .if_id_valid     (valid),
        .fetch_count     (fc),
        .flush_count     (flc)
    );

    fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10), .CNT_W(2)) dut2 (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr2),
        .imem_data       (imem_data2),
        .pc              (pc2),
        .if_id_instr     (instr2),
        .if_id_pc4       (pc4b),
        .if_id_valid     (valid2),
        .fetch_count     (fc2),
        .flush_count     (flc2)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic int sat(input int v, input int mx);
        return (v >= mx) ? mx : v + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference: what each edge must do, by priority of the inputs.
    always @(posedge clk) begin
        if (reset) begin
            m_pc    <= 32'h0;
            m_instr <= 32'h0;
            m_pc4   <= 32'h0;
            m_valid <= 1'b0;
            m_fc    <= 0;
            m_flc   <= 0;
            m_fc2   <= 0;
            m_flc2  <= 0;
        end else if (redirect_valid) begin
            m_pc    <= {redirect_target[31:2], 2'b00};
            m_instr <= 32'h0;
            m_pc4   <= 32'h0;
            m_valid <= 1'b0;
            m_flc   <= sat(m_flc, 65535);
            m_flc2  <= sat(m_flc2, 3);
        end else if (!stall) begin
            m_instr <= mem[m_pc[11:2]];
            m_pc4   <= m_pc + 32'd4;
            m_pc    <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_fc    <= sat(m_fc, 65535);
            m_fc2   <= sat(m_fc2, 3);
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("pc", pc, m_pc);
            chk("imem_addr", 32'(imem_addr), 32'(m_pc[11:2]));
            chk("if_id_instr", instr, m_instr);
            chk("if_id_pc4", pc4, m_pc4);
            chk("if_id_valid", 32'(valid), 32'(m_valid));
            chk("fetch_count", 32'(fc), m_fc);
            chk("flush_count", 32'(flc), m_flc);
            chk("pc_small", pc2, m_pc);
            chk("fetch_count_small", 32'(fc2), m_fc2);
            chk("flush_count_small", 32'(flc2), m_flc2);
        end
    end

    task automatic tick(input logic r, input logic s, input logic rv,
                        input logic [31:0] t);
        reset           = r;
        stall           = s;
        redirect_valid  = rv;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h2009_0003;
        mem[1] = 32'h200a_000a;
        mem[2] = 32'h200b_0008;
        mem[3] = 32'h200c_0004;

        // Reset
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 32'h44);
        check_en = 1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fc", 32'(fc), 32'h0);

        // Free run
        tick(0, 0, 0, 0);
        chk("run1_instr", instr, 32'h2009_0003);
        chk("run1_pc4", pc4, 32'h4);
        tick(0, 0, 0, 0);
        chk("run2_instr", instr, 32'h200a_000a);
        tick(0, 0, 0, 0);
        chk("run3_instr", instr, 32'h200b_0008);
        tick(0, 0, 0, 0);
        chk("run4_instr", instr, 32'h200c_0004);
        chk("run4_pc4", pc4, 32'h10);
        chk("run4_fc", 32'(fc), 32'd4);
        chk("run4_fc_small", 32'(fc2), 32'd3);

        // Redirect at pc=0xC to 0x20
        tick(1, 0, 0, 0);
        run(3);
        chk("pre_redir_pc", pc, 32'hC);
        tick(0, 0, 1, 32'h20);
        chk("redir_pc", pc, 32'h20);
        chk("redir_valid", 32'(valid), 32'h0);
        chk("redir_flc", 32'(flc), 32'd1);
        tick(0, 0, 0, 0);
        chk("redir_tgt_instr", instr, 32'h1000_0008);
        chk("redir_tgt_pc4", pc4, 32'h24);

        // Stall 3 cycles at pc=0x8
        tick(1, 0, 0, 0);
        run(2);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 0, 0);
            chk("stall_pc", pc, 32'h8);
            chk("stall_instr", instr, 32'h200a_000a);
            chk("stall_fc", 32'(fc), 32'd2);
        end
        tick(0, 0, 0, 0);
        chk("resume_pc", pc, 32'hC);
        chk("resume_instr", instr, 32'h200b_0008);

        // Stall and redirect together
        tick(0, 1, 1, 32'h40);
        chk("stred_pc", pc, 32'h40);
        chk("stred_valid", 32'(valid), 32'h0);
        chk("stred_flc", 32'(flc), 32'd1);

        // Redirect to pc+4 still flushes
        tick(0, 0, 1, 32'h44);
        chk("same_tgt_flc", 32'(flc), 32'd2);
        chk("same_tgt_valid", 32'(valid), 32'h0);

        // Reset during stall at pc=0x30
        tick(0, 0, 1, 32'h30);
        tick(0, 1, 0, 0);
        chk("pre_rst_pc", pc, 32'h30);
        tick(1, 1, 0, 0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_flc", 32'(flc), 32'h0);

        // Narrow counters saturate; unaligned target
        run(5);
        chk("sat_fc_small", 32'(fc2), 32'd3);
        chk("sat_fc_wide", 32'(fc), 32'd5);
        tick(0, 0, 1, 32'h23);
        chk("align_pc", pc, 32'h20);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 32'h100 + 32'(i * 4));
        chk("sat_flc_small", 32'(flc2), 32'd3);
        chk("sat_flc_wide", 32'(flc), 32'd5);

        // PC wrap; imem_addr truncates
        tick(0, 0, 1, 32'hFFFF_FFFC);
        chk("wrap_addr", 32'(imem_addr), 32'h3FF);
        tick(0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", pc4, 32'h0);
        chk("wrap_instr", instr, 32'h1000_03FF);
        run(3);

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
